// File: rtl/clock_switch_sequencer.sv
// -----------------------------------------------------------------------------
// clock_switch_sequencer
//
// Sequences glitch-free switching of a clock-source mux and the clock gate that
// follows it. Every change runs gate-off -> select -> settle -> gate-on, so the
// mux select only moves while the downstream gate is closed.
//
// Ports:
//   clock       always-on reference clock, all logic on its rising edge
//   reset       synchronous, active-low reset
//   req_valid   request present
//   req_ready   block is idle and out of reset, request can be accepted
//   req_sel     requested source
//   req_enable  1 = run on req_sel, 0 = stop the output clock
//   mux_sel     registered clock mux select
//   gate_en     registered clock gate enable
//   busy        a sequence is in progress
//   done        one-cycle pulse when a request completes
//   err         one-cycle pulse when an out-of-range run request is accepted
// -----------------------------------------------------------------------------
module clock_switch_sequencer #(
    parameter int NUM_CLOCKS    = 4,
    parameter int SEL_W         = $clog2(NUM_CLOCKS),
    parameter int OFF_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ON_CYCLES     = 4,
    parameter int RESET_SEL     = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_enable,
    output logic [SEL_W-1:0] mux_sel,
    output logic             gate_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_AB  = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > ON_CYCLES) ? MAX_AB : ON_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int SELX_W  = SEL_W + 1;

    // The counter is loaded with dwell-1 so that expiry (count == 0) lands on
    // exactly the dwell-th edge after entering the state.
    localparam logic [CNT_W-1:0]  OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ON_LOAD     = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [SELX_W-1:0] NUM_X       = SELX_W'(NUM_CLOCKS);
    localparam logic [SEL_W-1:0]  RST_SEL     = SEL_W'(RESET_SEL);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GATE_OFF = 2'd1;
    localparam logic [1:0] ST_SWITCH   = 2'd2;
    localparam logic [1:0] ST_GATE_ON  = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [SEL_W-1:0] tgt_sel_q, tgt_sel_d;
    logic             tgt_en_q,  tgt_en_d;
    logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
    logic             gate_en_q, gate_en_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic             accept_s;
    logic             bad_sel_s;

    assign req_ready = (state_q == ST_IDLE) && reset;
    assign accept_s  = req_valid && req_ready;
    assign bad_sel_s = ({1'b0, req_sel} >= NUM_X);
    assign mux_sel   = mux_sel_q;
    assign gate_en   = gate_en_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Next-state logic for the switch sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_sel_d = tgt_sel_q;
        tgt_en_d  = tgt_en_q;
        mux_sel_d = mux_sel_q;
        gate_en_d = gate_en_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tgt_sel_d = req_sel;
                    tgt_en_d  = req_enable;
                    if (req_enable) begin
                        if (bad_sel_s) begin
                            err_d = 1'b1;
                        end else if (gate_en_q && (req_sel == mux_sel_q)) begin
                            done_d = 1'b1;
                        end else if (gate_en_q) begin
                            gate_en_d = 1'b0;
                            state_d   = ST_GATE_OFF;
                            cnt_d     = OFF_LOAD;
                        end else begin
                            // Output already stopped: no gate-off dwell needed.
                            mux_sel_d = req_sel;
                            state_d   = ST_SWITCH;
                            cnt_d     = SETTLE_LOAD;
                        end
                    end else begin
                        if (gate_en_q) begin
                            gate_en_d = 1'b0;
                            state_d   = ST_GATE_OFF;
                            cnt_d     = OFF_LOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE_OFF: begin
                if (cnt_q == CNT_ZERO) begin
                    if (tgt_en_q) begin
                        mux_sel_d = tgt_sel_q;
                        state_d   = ST_SWITCH;
                        cnt_d     = SETTLE_LOAD;
                    end else begin
                        // Stop request: finish with the gate closed, select untouched.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SWITCH: begin
                if (cnt_q == CNT_ZERO) begin
                    gate_en_d = 1'b1;
                    state_d   = ST_GATE_ON;
                    cnt_d     = ON_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GATE_ON: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to idle with the gate closed.
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                gate_en_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            tgt_sel_q <= RST_SEL;
            tgt_en_q  <= 1'b0;
            mux_sel_q <= RST_SEL;
            gate_en_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_sel_q <= tgt_sel_d;
            tgt_en_q  <= tgt_en_d;
            mux_sel_q <= mux_sel_d;
            gate_en_q <= gate_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for clock_switch_sequencer.
// Instance A: default parameters, driven from a vector table.
// Instance B: NUM_CLOCKS = 3 and all dwell times 1, driven by hand sequences.
// -----------------------------------------------------------------------------
module tb_clock_switch_sequencer;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] sel;
        logic       en;
        int         reps;
        logic       rdy;
        logic [1:0] mux;
        logic       gate;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A signals
    logic       a_rst, a_vld, a_en;
    logic [1:0] a_sel;
    logic       a_rdy, a_gate, a_busy, a_done, a_err;
    logic [1:0] a_mux;

    // Instance B signals
    logic       b_rst, b_vld, b_en;
    logic [1:0] b_sel;
    logic       b_rdy, b_gate, b_busy, b_done, b_err;
    logic [1:0] b_mux;

    clock_switch_sequencer u_a (
        .clock(clk), .reset(a_rst), .req_valid(a_vld), .req_ready(a_rdy),
        .req_sel(a_sel), .req_enable(a_en), .mux_sel(a_mux), .gate_en(a_gate),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    clock_switch_sequencer #(
        .NUM_CLOCKS(3), .OFF_CYCLES(1), .SETTLE_CYCLES(1), .ON_CYCLES(1)
    ) u_b (
        .clock(clk), .reset(b_rst), .req_valid(b_vld), .req_ready(b_rdy),
        .req_sel(b_sel), .req_enable(b_en), .mux_sel(b_mux), .gate_en(b_gate),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Glitch-freedom monitor: a select change must see the gate closed before and after.
    logic [1:0] a_mux_prev = 2'd0, b_mux_prev = 2'd0;
    logic       a_gate_prev = 1'b0, b_gate_prev = 1'b0;
    always @(negedge clk) begin
        if (a_rst === 1'b1 && a_mux !== a_mux_prev)
            chk("a_mux_change_gate_closed", int'(a_gate_prev | a_gate), 0);
        if (b_rst === 1'b1 && b_mux !== b_mux_prev)
            chk("b_mux_change_gate_closed", int'(b_gate_prev | b_gate), 0);
        a_mux_prev  = a_mux;
        a_gate_prev = a_gate;
        b_mux_prev  = b_mux;
        b_gate_prev = b_gate;
    end

    vec_t vecs[$];

    task automatic add(input int rst, input int vld, input int sel, input int en, input int reps,
                       input int rdy, input int mux, input int gate, input int busy,
                       input int done, input int err);
        vec_t v;
        v.rst = rst[0]; v.vld = vld[0]; v.sel = sel[1:0]; v.en = en[0]; v.reps = reps;
        v.rdy = rdy[0]; v.mux = mux[1:0]; v.gate = gate[0]; v.busy = busy[0];
        v.done = done[0]; v.err = err[0];
        vecs.push_back(v);
    endtask

    task automatic bstep(input logic rst, input logic vld, input logic [1:0] sel, input logic en);
        b_rst = rst; b_vld = vld; b_sel = sel; b_en = en;
        @(negedge clk);
    endtask

    initial begin
        a_rst = 1'b0; a_vld = 1'b0; a_sel = 2'd0; a_en = 1'b0;
        b_rst = 1'b0; b_vld = 1'b0; b_sel = 2'd0; b_en = 1'b0;

        //   rst vld sel en reps | rdy mux gate busy done err
        add(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0);  // reset state
        add(1, 1, 2, 1, 1,   0, 2, 0, 1, 0, 0);  // start from stopped: select at once
        add(1, 0, 0, 0, 1,   0, 2, 0, 1, 0, 0);
        add(1, 0, 0, 0, 4,   0, 2, 1, 1, 0, 0);  // gate on after E2
        add(1, 0, 0, 0, 1,   1, 2, 1, 0, 1, 0);  // done after E6
        add(1, 0, 0, 0, 1,   1, 2, 1, 0, 0, 0);
        add(1, 1, 1, 1, 1,   0, 2, 0, 1, 0, 0);  // running 2 -> 1: gate off
        add(1, 0, 3, 0, 3,   0, 2, 0, 1, 0, 0);  // field changes ignored
        add(1, 0, 3, 0, 2,   0, 1, 0, 1, 0, 0);  // select after E4
        add(1, 0, 3, 0, 4,   0, 1, 1, 1, 0, 0);  // gate on after E6
        add(1, 0, 0, 0, 1,   1, 1, 1, 0, 1, 0);  // done after E10
        add(1, 0, 0, 0, 1,   1, 1, 1, 0, 0, 0);
        add(1, 1, 3, 0, 1,   0, 1, 0, 1, 0, 0);  // stop while running
        add(1, 0, 0, 0, 3,   0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0);  // done after E4, select kept
        add(1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0);
        add(1, 1, 2, 0, 1,   1, 1, 0, 0, 1, 0);  // repeat stop: immediate done
        add(1, 0, 0, 0, 2,   1, 1, 0, 0, 0, 0);
        add(1, 1, 3, 1, 1,   0, 3, 0, 1, 0, 0);  // start on 3, valid held after
        add(1, 1, 0, 1, 1,   0, 3, 0, 1, 0, 0);
        add(1, 1, 0, 1, 4,   0, 3, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1,   1, 3, 1, 0, 1, 0);  // done, second request waiting
        add(1, 1, 0, 1, 1,   0, 3, 0, 1, 0, 0);  // accepted on the done edge
        add(1, 0, 0, 0, 3,   0, 3, 0, 1, 0, 0);
        add(1, 0, 0, 0, 2,   0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 4,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1,   1, 0, 1, 0, 1, 0);  // same running source: immediate done
        add(1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
        add(1, 1, 2, 1, 1,   0, 0, 0, 1, 0, 0);  // switch 0 -> 2
        add(1, 0, 0, 0, 3,   0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1,   0, 2, 0, 1, 0, 0);  // in SWITCH
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);  // reset mid-sequence
        add(1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);  // ready on release
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1,   0, 1, 0, 1, 0, 0);  // accepted on first edge out of reset
        add(1, 0, 0, 0, 1,   0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 4,   0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,   1, 1, 1, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                a_rst = vecs[i].rst; a_vld = vecs[i].vld;
                a_sel = vecs[i].sel; a_en  = vecs[i].en;
                @(negedge clk);
                chk($sformatf("v%0d.%0d ready", i, r), int'(a_rdy),  int'(vecs[i].rdy));
                chk($sformatf("v%0d.%0d mux",   i, r), int'(a_mux),  int'(vecs[i].mux));
                chk($sformatf("v%0d.%0d gate",  i, r), int'(a_gate), int'(vecs[i].gate));
                chk($sformatf("v%0d.%0d busy",  i, r), int'(a_busy), int'(vecs[i].busy));
                chk($sformatf("v%0d.%0d done",  i, r), int'(a_done), int'(vecs[i].done));
                chk($sformatf("v%0d.%0d err",   i, r), int'(a_err),  int'(vecs[i].err));
            end
        end
        a_rst = 1'b1; a_vld = 1'b0;

        // Instance B: out-of-range and minimum dwell corner cases.
        bstep(1'b0, 1'b0, 2'd0, 1'b0);
        bstep(1'b0, 1'b0, 2'd0, 1'b0);
        chk("b reset ready", int'(b_rdy), 0);
        chk("b reset mux", int'(b_mux), 0);
        chk("b reset gate", int'(b_gate), 0);

        bstep(1'b1, 1'b1, 2'd3, 1'b1);
        chk("b oor err", int'(b_err), 1);
        chk("b oor ready", int'(b_rdy), 1);
        chk("b oor busy", int'(b_busy), 0);
        chk("b oor done", int'(b_done), 0);
        chk("b oor mux", int'(b_mux), 0);
        chk("b oor gate", int'(b_gate), 0);
        bstep(1'b1, 1'b0, 2'd0, 1'b0);
        chk("b oor err clears", int'(b_err), 0);
        chk("b oor no done", int'(b_done), 0);

        bstep(1'b1, 1'b1, 2'd3, 1'b0);
        chk("b stop oor-sel done", int'(b_done), 1);
        chk("b stop oor-sel no err", int'(b_err), 0);

        bstep(1'b1, 1'b1, 2'd1, 1'b1);
        chk("b start mux", int'(b_mux), 1);
        chk("b start gate", int'(b_gate), 0);
        chk("b start busy", int'(b_busy), 1);
        bstep(1'b1, 1'b0, 2'd0, 1'b0);
        chk("b start gate on", int'(b_gate), 1);
        chk("b start no done yet", int'(b_done), 0);
        bstep(1'b1, 1'b0, 2'd0, 1'b0);
        chk("b start done", int'(b_done), 1);
        chk("b start idle", int'(b_busy), 0);

        bstep(1'b1, 1'b1, 2'd2, 1'b1);
        chk("b sw gate off", int'(b_gate), 0);
        chk("b sw mux held", int'(b_mux), 1);
        chk("b sw done early", int'(b_done), 0);
        for (int k = 1; k <= 3; k++) begin
            bstep(1'b1, 1'b0, 2'd0, 1'b0);
            chk($sformatf("b sw done at +%0d", k), int'(b_done), (k == 3) ? 1 : 0);
            chk($sformatf("b sw mux at +%0d", k), int'(b_mux), 2);
            chk($sformatf("b sw gate at +%0d", k), int'(b_gate), (k >= 2) ? 1 : 0);
        end
        chk("b sw ready", int'(b_rdy), 1);

        bstep(1'b1, 1'b1, 2'd3, 1'b1);
        chk("b run oor err", int'(b_err), 1);
        chk("b run oor mux", int'(b_mux), 2);
        chk("b run oor gate", int'(b_gate), 1);
        chk("b run oor done", int'(b_done), 0);
        bstep(1'b1, 1'b0, 2'd0, 1'b0);
        chk("b run oor err clears", int'(b_err), 0);
        chk("b run oor no done", int'(b_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
